// File: rtl/bcd_entry_adder_if.sv
// Keypad-side bundle for the BCD entry adder: key/operator strobes in,
// display and status out.
interface bcd_entry_adder_if #(
    parameter int DIGITS = 4
);
    logic                  key_valid;
    logic [3:0]            key_code;
    logic                  op_add;
    logic                  op_eq;
    logic                  clear;
    logic [4*DIGITS-1:0]   disp;
    logic                  busy;
    logic                  overflow;
    logic                  result_valid;

    modport master (
        output key_valid, key_code, op_add, op_eq, clear,
        input  disp, busy, overflow, result_valid
    );

    modport slave (
        input  key_valid, key_code, op_add, op_eq, clear,
        output disp, busy, overflow, result_valid
    );
endinterface

// File: rtl/bcd_entry_adder.sv
// Calculator-style BCD entry adder: two operands keyed in digit by digit,
// summed serially one digit per clock, LSD first, with chained addition.
module bcd_entry_adder #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_entry_adder_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DIGITS);

    typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, SHOW} state_e;

    state_e          state_q;
    logic [W-1:0]    a_q, b_q, s_q;
    logic            carry_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q;
    logic            rv_q;

    logic            digit_key;
    logic            room;
    logic [4:0]      dig_t;
    logic [3:0]      dig_sum_d;
    logic            carry_d;
    logic [W-1:0]    key_ext;

    assign digit_key = bus.key_valid && (bus.key_code <= 4'd9);
    assign room      = (cnt_q != FULL_CNT);
    assign key_ext   = W'(bus.key_code);

    // One BCD digit of the serial adder, selected by the running index.
    always_comb begin
        dig_t     = {1'b0, a_q[idx_q*4 +: 4]} + {1'b0, b_q[idx_q*4 +: 4]} + {4'b0, carry_q};
        dig_sum_d = dig_t[3:0];
        carry_d   = 1'b0;
        if (dig_t >= 5'd10) begin
            dig_sum_d = 4'(dig_t - 5'd10);
            carry_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else if (bus.clear) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            unique case (state_q)
                ENTER_A: begin
                    if (bus.op_add) begin
                        state_q <= ENTER_B;
                        b_q     <= '0;
                        cnt_q   <= '0;
                    end else if (digit_key && room) begin
                        a_q   <= (a_q << 4) | key_ext;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ENTER_B: begin
                    // op_add is not applicable here, so a coincident key still acts.
                    if (bus.op_eq) begin
                        state_q <= CALC;
                        idx_q   <= '0;
                        carry_q <= 1'b0;
                    end else if (digit_key && room) begin
                        b_q   <= (b_q << 4) | key_ext;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CALC: begin
                    s_q[idx_q*4 +: 4] <= dig_sum_d;
                    carry_q           <= carry_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= SHOW;
                        ovf_q   <= carry_d;
                        rv_q    <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (bus.op_add) begin
                        state_q <= ENTER_B;
                        a_q     <= s_q;
                        b_q     <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end else if (digit_key) begin
                        state_q <= ENTER_A;
                        a_q     <= key_ext;
                        cnt_q   <= CW'(1);
                        ovf_q   <= 1'b0;
                    end
                end
                default: state_q <= ENTER_A;
            endcase
        end
    end

    always_comb begin
        bus.disp = a_q;
        unique case (state_q)
            ENTER_B: bus.disp = b_q;
            SHOW:    bus.disp = s_q;
            default: bus.disp = a_q;
        endcase
    end

    assign bus.busy         = (state_q == CALC);
    assign bus.overflow     = ovf_q;
    assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_bcd_entry_adder.sv
// Bench for bcd_entry_adder: directed keypad scenarios plus randomized
// entry sequences checked against a decimal-arithmetic reference model.
module tb_bcd_entry_adder;
    localparam int DIGITS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    bcd_entry_adder_if #(.DIGITS(DIGITS)) bus ();

    bcd_entry_adder #(.DIGITS(DIGITS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] k);
        bus.key_code  = k;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic do_add();
        bus.op_add = 1'b1; tick(); bus.op_add = 1'b0;
    endtask

    task automatic do_eq();
        bus.op_eq = 1'b1; tick(); bus.op_eq = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Called right after the op_eq edge: walks the busy window with a bound.
    task automatic calc_check(input string tag, input int a, input int s, input logic ov);
        int n = 0;
        chk({tag, "_busy0"}, 32'(bus.busy), 32'd1);
        chk({tag, "_dispA"}, 32'(bus.disp), to_bcd(a));
        while (bus.busy && n < 20) begin
            chk({tag, "_norv"}, 32'(bus.result_valid), 32'd0);
            n++;
            tick();
        end
        chk({tag, "_busycyc"}, 32'(n), 32'(DIGITS));
        chk({tag, "_rv"}, 32'(bus.result_valid), 32'd1);
        chk({tag, "_sum"}, 32'(bus.disp), to_bcd(s));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(ov));
        tick();
        chk({tag, "_rvoff"}, 32'(bus.result_valid), 32'd0);
        chk({tag, "_hold"}, 32'(bus.disp), to_bcd(s));
    endtask

    // Reference: enter random keys (some invalid, possibly too many) into an
    // integer operand, keeping only the first DIGITS decimal digits.
    task automatic enter_rand(input string tag, output int val);
        int cnt = 0;
        int n = $urandom_range(1, 6);
        val = 0;
        for (int i = 0; i < n; i++) begin
            logic [3:0] k;
            if ($urandom_range(0, 4) == 0) k = 4'($urandom_range(10, 15));
            else k = 4'($urandom_range(0, 9));
            key(k);
            if (k <= 9 && cnt < DIGITS) begin
                val = val * 10 + int'(k);
                cnt++;
            end
        end
        chk({tag, "_entry"}, 32'(bus.disp), to_bcd(val));
    endtask

    initial begin
        int rv_seen;
        int a, b, s, lim;
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        bus.key_valid = 1'b0; bus.key_code = 4'd0;
        bus.op_add = 1'b0; bus.op_eq = 1'b0; bus.clear = 1'b0;

        #12;
        chk("rst_disp", 32'(bus.disp), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ovf",  32'(bus.overflow), 32'd0);
        chk("rst_rv",   32'(bus.result_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // 123 + 45, then chained + 32
        key(1); key(2); key(3);
        chk("s1_a", 32'(bus.disp), 32'h0123);
        do_add();
        chk("s1_bclr", 32'(bus.disp), 32'h0000);
        key(4); key(5);
        chk("s1_b", 32'(bus.disp), 32'h0045);
        do_eq();
        calc_check("s1", 123, 168, 1'b0);
        do_add();
        chk("s4_bclr", 32'(bus.disp), 32'h0000);
        key(3); key(2);
        do_eq();
        calc_check("s4", 168, 200, 1'b0);

        // 9999 + 0001: carry ripples through every digit
        do_clear();
        key(9); key(9); key(9); key(9);
        do_add();
        key(0); key(0); key(0); key(1);
        do_eq();
        calc_check("s2", 9999, 0, 1'b1);

        // Fifth digit and invalid code ignored
        do_clear();
        chk("clr_ovf", 32'(bus.overflow), 32'd0);
        key(1); key(2); key(3); key(4); key(5);
        chk("s3_full", 32'(bus.disp), 32'h1234);
        key(11);
        chk("s3_inv", 32'(bus.disp), 32'h1234);

        // Digit key in SHOW restarts A
        do_add(); key(6); do_eq();
        calc_check("s5", 1234, 1240, 1'b0);
        key(7);
        chk("show_key", 32'(bus.disp), 32'h0007);
        chk("show_key_ovf", 32'(bus.overflow), 32'd0);

        // op_eq + op_add together in ENTER_B -> CALC; clear aborts silently
        do_add(); key(8);
        bus.op_eq = 1'b1; bus.op_add = 1'b1; tick();
        bus.op_eq = 1'b0; bus.op_add = 1'b0;
        chk("s6_calc", 32'(bus.busy), 32'd1);
        tick();
        do_clear();
        rv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            rv_seen += int'(bus.result_valid);
            tick();
        end
        chk("s6_norv", 32'(rv_seen), 32'd0);
        chk("s6_disp", 32'(bus.disp), 32'd0);
        chk("s6_busy", 32'(bus.busy), 32'd0);

        // Async reset mid-CALC
        key(5); do_add(); key(6); do_eq(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_disp", 32'(bus.disp), 32'd0);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_ovf",  32'(bus.overflow), 32'd0);
        chk("ar_rv",   32'(bus.result_valid), 32'd0);
        tick(); tick();
        #3 rst_n = 1'b1;
        tick();
        chk("ar_rv2", 32'(bus.result_valid), 32'd0);
        key(7);
        chk("ar_keyA", 32'(bus.disp), 32'h0007);
        do_add();
        chk("ar_enterA", 32'(bus.disp), 32'h0000);

        // Randomized operands, with occasional chained third operand
        for (int it = 0; it < 25; it++) begin
            do_clear();
            enter_rand("rA", a);
            do_add();
            enter_rand("rB", b);
            do_eq();
            s = (a + b) % lim;
            calc_check("rnd", a, s, (a + b) >= lim);
            if ($urandom_range(0, 1) == 1) begin
                do_add();
                chk("rch_bclr", 32'(bus.disp), 32'd0);
                enter_rand("rC", b);
                do_eq();
                calc_check("rch", s, (s + b) % lim, (s + b) >= lim);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
